// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end.
// Owns the PC and issues one outstanding req/ack fetch at a time.
// Buffers fetched words in a prefetch FIFO that feeds IF/ID as {instr, pc+4}.
// A taken branch redirects fetch, flushes the FIFO and kills any unacked request.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [31:0]                imem_data_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    input  logic                       id_ready_i,
    output logic                       ifid_valid_o,
    output logic [31:0]                ifid_instr_o,
    output logic [31:0]                ifid_pc4_o,
    output logic [$clog2(DEPTH):0]     fifo_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // S_KILL: a request from before a redirect is still outstanding; its data must be dropped
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     pend_pc_q, pend_pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   count_nf;
    logic [63:0]     mem_q [DEPTH];

    logic            push;
    logic            pop;
    logic            flush;

    // FIFO control: redirect flushes, push only for a live, acked, non-redirected fetch
    always_comb begin
        flush = redirect_i;
        push  = (state_q == S_REQ) && imem_ack_i && !redirect_i && (count_q < DEPTH_C);
        pop   = (count_q != '0) && id_ready_i;
        unique case ({push, pop})
            2'b10:   count_nf = count_q + CW'(1);
            2'b01:   count_nf = count_q - CW'(1);
            default: count_nf = count_q;
        endcase
        count_d  = flush ? '0 : count_nf;
        wr_ptr_d = flush ? '0 : (push ? wr_ptr_q + AW'(1) : wr_ptr_q);
        rd_ptr_d = flush ? '0 : (pop  ? rd_ptr_q + AW'(1) : rd_ptr_q);
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (redirect_i || (count_q < DEPTH_C)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect_i) begin
                    state_d = imem_ack_i ? S_REQ : S_KILL;
                end else if (imem_ack_i) begin
                    state_d = (count_nf < DEPTH_C) ? S_REQ : S_IDLE;
                end
            end
            S_KILL: begin
                if (imem_ack_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: memory side from state/PC, IF/ID side straight from FIFO storage
    always_comb begin
        imem_req_o   = (state_q != S_IDLE);
        imem_addr_o  = fetch_pc_q;
        ifid_valid_o = (count_q != '0);
        ifid_instr_o = mem_q[rd_ptr_q][63:32];
        ifid_pc4_o   = mem_q[rd_ptr_q][31:0];
        fifo_count_o = count_q;
    end

    // PC bookkeeping: fetch_pc advances on accepted fetches, pend_pc remembers a target during KILL
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                end
            end
            S_REQ: begin
                if (redirect_i) begin
                    if (imem_ack_i) begin
                        fetch_pc_d = redirect_pc_i;
                    end else begin
                        pend_pc_d = redirect_pc_i;
                    end
                end else if (imem_ack_i) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            S_KILL: begin
                if (redirect_i) begin
                    pend_pc_d = redirect_pc_i;
                end
                if (imem_ack_i) begin
                    fetch_pc_d = redirect_i ? redirect_pc_i : pend_pc_q;
                end
            end
            default: ;
        endcase
    end

    // Control registers: PCs, FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage: data only, no reset needed since count gates validity
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {imem_data_i, fetch_pc_q + 32'd4};
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run
// against a transaction-level queue model.
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [2:0]  count;

    // Second instance for the PC wrap-around case
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_data;
    logic        w_redirect;
    logic [31:0] w_rpc;
    logic        w_ready;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;
    logic [2:0]  w_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_data_i(data),
        .redirect_i(redirect), .redirect_pc_i(rpc),
        .id_ready_i(ready),
        .ifid_valid_o(valid), .ifid_instr_o(instr), .ifid_pc4_o(pc4),
        .fifo_count_o(count)
    );

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_ack_i(w_ack), .imem_data_i(w_data),
        .redirect_i(w_redirect), .redirect_pc_i(w_rpc),
        .id_ready_i(w_ready),
        .ifid_valid_o(w_valid), .ifid_instr_o(w_instr), .ifid_pc4_o(w_pc4),
        .fifo_count_o(w_count)
    );

    assign w_ack      = 1'b1;
    assign w_data     = ~w_addr;
    assign w_redirect = 1'b0;
    assign w_rpc      = 32'h0;
    assign w_ready    = 1'b0;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ack = 1'b0; ready = 1'b0; redirect = 1'b0; rpc = '0; data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ack = 1'b0; ready = 1'b0; redirect = 1'b0; rpc = '0; data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (req !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%b exp=1", req); end
        ack = 1'b1; data = 32'h1111_2222;
        @(negedge clk);
        ack = 1'b0;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL rst_pre_count got=%0d exp=1", count); end
        rst = 1'b1;
        #1;
        total++; if (req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", req); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", addr); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++; if (req !== 1'b0) begin bad++; $display("FAIL rst_release_req got=%b exp=0", req); end
        @(posedge clk);
        #1;
        total++; if (req !== 1'b1) begin bad++; $display("FAIL rst_after_req got=%b exp=1", req); end
        total++; if (addr !== 32'h0) begin bad++; $display("FAIL rst_after_addr got=%h exp=0", addr); end
    endtask

    task automatic test_streaming();
        @(negedge clk);
        ack = 1'b1; ready = 1'b1; data = f(32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", k, valid); end
            total++; if (pc4 !== 32'(4 * (k + 1))) begin bad++; $display("FAIL stream_pc4[%0d] got=%h exp=%h", k, pc4, 32'(4 * (k + 1))); end
            total++; if (instr !== f(32'(4 * k))) begin bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", k, instr, f(32'(4 * k))); end
            total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, count); end
            data = f(32'(4 * (k + 1)));
        end
        ack = 1'b0; ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic seen;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ack = 1'b1; data = f(32'(4 * i));
        end
        @(negedge clk);
        ack = 1'b0;
        total++; if (req !== 1'b0) begin bad++; $display("FAIL bp_full_req got=%b exp=0", req); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_full_count got=%0d exp=4", count); end
        ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (pc4 !== 32'(4 * (i + 1))) begin bad++; $display("FAIL bp_drain_pc4[%0d] got=%h exp=%h", i, pc4, 32'(4 * (i + 1))); end
            total++; if (instr !== f(32'(4 * i))) begin bad++; $display("FAIL bp_drain_instr[%0d] got=%h exp=%h", i, instr, f(32'(4 * i))); end
            if (req === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL bp_req_reassert got=%b exp=1", seen); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL bp_empty_count got=%0d exp=0", count); end
        total++; if (addr !== 32'h10) begin bad++; $display("FAIL bp_next_addr got=%h exp=10", addr); end
    endtask

    task automatic test_redirect_wait();
        total++; if (req !== 1'b1) begin bad++; $display("FAIL rw_req got=%b exp=1", req); end
        redirect = 1'b1; rpc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (addr !== 32'h10) begin bad++; $display("FAIL rw_hold_addr[%0d] got=%h exp=10", i, addr); end
            total++; if (req !== 1'b1) begin bad++; $display("FAIL rw_hold_req[%0d] got=%b exp=1", i, req); end
            if (i < 2) @(negedge clk);
        end
        ack = 1'b1; data = 32'hDEAD_BEEF;
        @(negedge clk);
        ack = 1'b0;
        total++; if (addr !== 32'h100) begin bad++; $display("FAIL rw_new_addr got=%h exp=100", addr); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rw_count got=%0d exp=0", count); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rw_valid got=%b exp=0", valid); end
    endtask

    task automatic test_simultaneous();
        ready = 1'b0; ack = 1'b1; data = f(32'h100);
        @(negedge clk);
        data = f(32'h104);
        @(negedge clk);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL sim_pre_count got=%0d exp=2", count); end
        ack = 1'b1; ready = 1'b1; redirect = 1'b1; rpc = 32'h40; data = 32'hBAD0_BAD0;
        @(negedge clk);
        redirect = 1'b0; ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL sim_count got=%0d exp=0", count); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL sim_valid got=%b exp=0", valid); end
        total++; if (addr !== 32'h40) begin bad++; $display("FAIL sim_addr got=%h exp=40", addr); end
        data = f(32'h40);
        @(negedge clk);
        ack = 1'b0;
        total++; if (pc4 !== 32'h44) begin bad++; $display("FAIL sim_next_pc4 got=%h exp=44", pc4); end
        total++; if (instr !== f(32'h40)) begin bad++; $display("FAIL sim_next_instr got=%h exp=%h", instr, f(32'h40)); end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        total++; if (w_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_first_addr got=%h exp=fffffffc", w_addr); end
        @(negedge clk);
        total++; if (w_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", w_valid); end
        total++; if (w_pc4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h exp=0", w_pc4); end
        total++; if (w_instr !== 32'h3) begin bad++; $display("FAIL wrap_instr got=%h exp=3", w_instr); end
        total++; if (w_addr !== 32'h0) begin bad++; $display("FAIL wrap_second_addr got=%h exp=0", w_addr); end
    endtask

    // Reference: queue of delivered entries, next useful PC, and a kill flag
    // marking that the outstanding request belongs to a discarded path.
    task automatic test_random();
        logic [63:0] m_q[$];
        logic [63:0] tmp;
        logic        m_kill;
        logic [31:0] m_pc;
        logic        prev_req, prev_ack;
        logic [31:0] prev_addr;
        int          idle_run;
        do_reset();
        m_kill = 1'b0; m_pc = 32'h0; idle_run = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        repeat (3000) begin
            @(negedge clk);
            total++; if (valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_valid got=%b exp=%b", valid, m_q.size() != 0); end
            total++; if (int'(count) != m_q.size()) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", count, m_q.size()); end
            if (m_q.size() != 0) begin
                total++; if ({instr, pc4} !== m_q[0]) begin bad++; $display("FAIL rnd_head got=%h exp=%h", {instr, pc4}, m_q[0]); end
            end
            if (req === 1'b1 && !m_kill) begin
                total++; if (addr !== m_pc) begin bad++; $display("FAIL rnd_addr got=%h exp=%h", addr, m_pc); end
            end
            if (prev_req && !prev_ack) begin
                total++; if (req !== 1'b1 || addr !== prev_addr) begin bad++; $display("FAIL rnd_hold got=%b/%h exp=1/%h", req, addr, prev_addr); end
            end
            if (m_kill) begin
                total++; if (req !== 1'b1) begin bad++; $display("FAIL rnd_kill_req got=%b exp=1", req); end
            end
            idle_run = (req !== 1'b1 && m_q.size() < DEPTH) ? idle_run + 1 : 0;
            total++; if (idle_run > 3) begin bad++; $display("FAIL rnd_starve got=%0d exp<=3", idle_run); end

            ack      = ($urandom_range(0, 9) < 6);
            ready    = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 29) == 0);
            rpc      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            data     = $urandom;

            if (redirect) begin
                m_q.delete();
                if (req === 1'b1) m_kill = !ack;
                m_pc = rpc;
            end else begin
                if (ready && m_q.size() != 0) tmp = m_q.pop_front();
                if (req === 1'b1 && ack) begin
                    if (m_kill) begin
                        m_kill = 1'b0;
                    end else begin
                        m_q.push_back({data, m_pc + 32'd4});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            prev_req = (req === 1'b1); prev_ack = ack; prev_addr = addr;
        end
        @(negedge clk);
        ack = 1'b0; ready = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_redirect_wait();
        test_simultaneous();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
